// File: rtl/dual_cpu_bus_arbiter_if.sv
// Bus bundle between the two CPU cores, the arbiter and the memory port.
// The arbiter connects through the slave modport; the core/memory side uses master.
interface dual_cpu_bus_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) ();
    // core request side
    logic [1:0]    req;
    logic [1:0]    we;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic [1:0]    cpu_pause;
    logic          cpu_sel;
    logic [1:0]    done;
    logic [DW-1:0] rdata;
    logic          bus_err;
    // memory port side
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, mem_rdata, mem_ack,
        output cpu_pause, cpu_sel, done, rdata, bus_err,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, mem_rdata, mem_ack,
        input  cpu_pause, cpu_sel, done, rdata, bus_err,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dual_cpu_bus_arbiter.sv
// Two-core shared-bus arbiter: round-robin grant, single memory port, bounded
// wait with forced error completion, one-cycle done pulse per transaction.
module dual_cpu_bus_arbiter #(
    parameter int unsigned   AW       = 32,
    parameter int unsigned   DW       = 32,
    parameter int unsigned   TIMEOUT  = 16,
    parameter logic [DW-1:0] ERR_DATA = DW'(32'hDEAD_BEEF)
) (
    input logic                   clk,
    input logic                   rst,
    dual_cpu_bus_arbiter_if.slave bus
);
    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e        state_q, state_d;
    logic          sel_q, sel_d;
    logic          last_grant_q, last_grant_d;
    logic [1:0]    done_q, done_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          bus_err_q, bus_err_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [CW-1:0] count_q, count_d;
    logic          grant;

    // On contention the core that did not win last time gets the bus.
    assign grant = (bus.req == 2'b11) ? ~last_grant_q : bus.req[1];

    // Next-state logic for arbitration, memory access and completion.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        done_d       = done_q;
        rdata_d      = rdata_q;
        bus_err_d    = bus_err_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        count_d      = count_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req != 2'b00) begin
                    sel_d       = grant;
                    mem_we_d    = bus.we[grant];
                    mem_addr_d  = grant ? bus.addr1 : bus.addr0;
                    mem_wdata_d = grant ? bus.wdata1 : bus.wdata0;
                    mem_req_d   = 1'b1;
                    count_d     = '0;
                    state_d     = StBusy;
                end
            end
            StBusy: begin
                if (bus.mem_ack) begin
                    rdata_d   = bus.mem_rdata;
                    done_d    = sel_q ? 2'b10 : 2'b01;
                    bus_err_d = 1'b0;
                    mem_req_d = 1'b0;
                    state_d   = StResp;
                end else if (count_q == CW'(TIMEOUT - 1)) begin
                    rdata_d   = ERR_DATA;
                    done_d    = sel_q ? 2'b10 : 2'b01;
                    bus_err_d = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = StResp;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            StResp: begin
                done_d       = 2'b00;
                bus_err_d    = 1'b0;
                last_grant_d = sel_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b1;
            done_q       <= 2'b00;
            rdata_q      <= '0;
            bus_err_q    <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            done_q       <= done_d;
            rdata_q      <= rdata_d;
            bus_err_q    <= bus_err_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            count_q      <= count_d;
        end
    end

    // A requesting core is stalled except in its own completion cycle.
    always_comb begin
        bus.cpu_pause[0] = bus.req[0] & ~((state_q == StResp) & ~sel_q);
        bus.cpu_pause[1] = bus.req[1] & ~((state_q == StResp) & sel_q);
    end

    assign bus.cpu_sel   = sel_q;
    assign bus.done      = done_q;
    assign bus.rdata     = rdata_q;
    assign bus.bus_err   = bus_err_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_dual_cpu_bus_arbiter.sv
// Randomized two-core traffic against a transaction-level scoreboard.
module tb_dual_cpu_bus_arbiter;
    localparam int unsigned AW       = 32;
    localparam int unsigned DW       = 32;
    localparam int unsigned TIMEOUT  = 16;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dual_cpu_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dual_cpu_bus_arbiter #(
        .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            delay;      // ack in BUSY cycle index 'delay'; >= TIMEOUT never acks
        int unsigned   raise_cyc;  // cycle in which the core raised the request
    } txn_t;

    txn_t        exp_q[2][$];
    int unsigned cyc = 0;
    bit          mon_en = 0, chk_rst = 0, drv_en = 0, stim_done = 0;
    int          n_tests = 0, n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Contents of the simulated memory for reads.
    function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic raise_txn(input int i, input txn_t t);
        if (i == 0) begin
            bus.addr0  = t.addr;
            bus.wdata0 = t.wdata;
        end else begin
            bus.addr1  = t.addr;
            bus.wdata1 = t.wdata;
        end
        bus.we[i]  = t.we;
        bus.req[i] = 1'b1;
        exp_q[i].push_back(t);
    endtask

    task automatic raise(input int i);
        txn_t t;
        t.we        = 1'($urandom % 2);
        t.addr      = $urandom;
        t.wdata     = $urandom;
        t.delay     = ($urandom % 8 == 0) ? 15 + int'($urandom % 6) : int'($urandom % 6);
        t.raise_cyc = cyc;
        raise_txn(i, t);
    endtask

    // One clock of core behaviour: drop or replace a request on its done pulse.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (bus.req[i] && bus.done[i]) begin
                if (drv_en && ($urandom % 2 == 1)) raise(i);
                else bus.req[i] = 1'b0;
            end else if (!bus.req[i] && drv_en && ($urandom % 3 == 0)) begin
                raise(i);
            end
        end
    endtask

    initial begin
        txn_t t;
        bus.req = 2'b00; bus.we = 2'b00;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_rst = 1; rst = 1'b0;
        @(posedge clk);
        #1;
        chk_rst = 0; mon_en = 1; drv_en = 1;
        for (int k = 0; k < 1500; k++) step();
        drv_en = 0;
        for (int k = 0; k < 300 && bus.req != 2'b00; k++) step();
        step();
        // Reset in the 3rd BUSY cycle of a never-acked read.
        t.we = 1'b0; t.addr = 32'h100; t.wdata = '0; t.delay = 100; t.raise_cyc = cyc;
        raise_txn(0, t);
        for (int k = 0; k < 20 && !bus.mem_req; k++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1; mon_en = 0;
        @(posedge clk);
        #1;
        rst = 1'b0; bus.req = 2'b00; chk_rst = 1;
        @(posedge clk);
        #1;
        chk_rst = 0; mon_en = 1;
        // Simultaneous requests straight after reset: CPU0 must win.
        t.we = 1'b0; t.addr = 32'h40; t.wdata = '0; t.delay = 1; t.raise_cyc = cyc;
        raise_txn(0, t);
        t.we = 1'b1; t.addr = 32'h20; t.wdata = 32'h55AA; t.delay = 4; t.raise_cyc = cyc;
        raise_txn(1, t);
        for (int k = 0; k < 100 && bus.req != 2'b00; k++) step();
        repeat (3) step();
        stim_done = 1;
    end

    // ---------------- memory responder ----------------
    int resp_cnt = 0, resp_delay = 0;
    initial begin
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_req) begin
                if (resp_cnt == 0)
                    resp_delay = (exp_q[bus.cpu_sel].size() > 0) ? exp_q[bus.cpu_sel][$].delay : 0;
                bus.mem_ack   = (resp_cnt == resp_delay);
                bus.mem_rdata = bus.mem_ack ? mem_model(bus.mem_addr) : $urandom;
                resp_cnt++;
            end else begin
                // Stray acks outside a transaction must be ignored.
                resp_cnt      = 0;
                bus.mem_ack   = ($urandom % 4 == 0);
                bus.mem_rdata = $urandom;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int            rd_idx[2];
    bit            last_served, g_core, prev_mem_req, prev_done, prev_quiet, prev_pend, finished;
    int            busy_len;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          lat_we;

    always @(negedge clk) begin : mon
        txn_t e;
        bit   ok, oth;
        logic g;
        if (chk_rst) begin
            chk("rst_done", bus.done, 0);
            chk("rst_bus_err", bus.bus_err, 0);
            chk("rst_mem_req", bus.mem_req, 0);
            chk("rst_cpu_sel", bus.cpu_sel, 0);
            chk("rst_rdata", bus.rdata, 0);
            chk("rst_mem_we", bus.mem_we, 0);
            chk("rst_mem_addr", bus.mem_addr, 0);
            chk("rst_mem_wdata", bus.mem_wdata, 0);
            chk("rst_cpu_pause", bus.cpu_pause, bus.req);
        end
        if (!mon_en) begin
            rd_idx[0] = exp_q[0].size();
            rd_idx[1] = exp_q[1].size();
            last_served = 1'b1;
            prev_mem_req = 0; prev_done = 0; prev_quiet = 0; prev_pend = 0;
            busy_len = 0;
        end else begin
            chk("cpu_pause", bus.cpu_pause, bus.req & ~bus.done);
            if (prev_quiet && prev_pend) chk("grant_latency", bus.mem_req, 1);
            if (bus.done != 2'b00) begin
                chk("done_core", bus.done, g_core ? 2'b10 : 2'b01);
                chk("done_single_cycle", prev_done, 0);
                chk("mem_req_low_in_resp", bus.mem_req, 0);
                ok = rd_idx[g_core] < exp_q[g_core].size();
                chk("done_pending", ok, 1);
                if (ok) begin
                    e = exp_q[g_core][rd_idx[g_core]];
                    rd_idx[g_core]++;
                    chk("bus_err", bus.bus_err, e.delay >= int'(TIMEOUT));
                    if (e.delay >= int'(TIMEOUT)) chk("rdata_err", bus.rdata, ERR_DATA);
                    else if (!e.we) chk("rdata", bus.rdata, mem_model(e.addr));
                    chk("busy_len", busy_len,
                        (e.delay >= int'(TIMEOUT)) ? TIMEOUT : e.delay + 1);
                    last_served = g_core;
                end
            end
            if (bus.mem_req && !prev_mem_req) begin
                g  = bus.cpu_sel;
                ok = (rd_idx[g] < exp_q[g].size()) && (exp_q[g][rd_idx[g]].raise_cyc < cyc);
                chk("grant_pending", ok, 1);
                oth = (rd_idx[!g] < exp_q[!g].size()) && (exp_q[!g][rd_idx[!g]].raise_cyc < cyc);
                if (oth) chk("round_robin", g != last_served, 1);
                g_core = g;
                if (ok) begin
                    e = exp_q[g][rd_idx[g]];
                    chk("mem_addr", bus.mem_addr, e.addr);
                    chk("mem_we", bus.mem_we, e.we);
                    chk("mem_wdata", bus.mem_wdata, e.wdata);
                end
                lat_addr = bus.mem_addr; lat_we = bus.mem_we; lat_wdata = bus.mem_wdata;
            end else if (bus.mem_req) begin
                chk("busy_stable_addr", bus.mem_addr, lat_addr);
                chk("busy_stable_wdata", {bus.mem_we, bus.cpu_sel, bus.mem_wdata},
                    {lat_we, g_core, lat_wdata});
            end
            busy_len     = bus.mem_req ? busy_len + 1 : 0;
            prev_pend    = (rd_idx[0] < exp_q[0].size()) || (rd_idx[1] < exp_q[1].size());
            prev_quiet   = !bus.mem_req && (bus.done == 2'b00);
            prev_mem_req = bus.mem_req;
            prev_done    = |bus.done;
        end
        if (stim_done && !finished) begin
            finished = 1;
            chk("drained_cpu0", exp_q[0].size() - rd_idx[0], 0);
            chk("drained_cpu1", exp_q[1].size() - rd_idx[1], 0);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end
endmodule
